// File: rtl/sdtap_dma.sv
// SD-card sector reader: issues CMD17 per sector and streams the 512 data bytes
// into the tapdata RAM; the CPU owns the SD controller whenever the engine is idle.
module sdtap_dma #(
  parameter int R1_TRIES    = 8,
  parameter int TOKEN_TRIES = 4096
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] lba,
  input  logic [7:0]  count,
  input  logic [16:0] dst,
  output logic        busy,
  output logic        done,
  output logic        error,
  input  logic        cpu_sd_signal,
  input  logic [1:0]  cpu_sd_cmd,
  input  logic [7:0]  cpu_sd_out,
  output logic [7:0]  cpu_sd_din,
  output logic        cpu_sd_busy,
  output logic        cpu_sd_timeout,
  output logic        sd_signal,
  output logic [1:0]  sd_cmd,
  output logic [7:0]  sd_out,
  input  logic [7:0]  sd_din,
  input  logic        sd_busy,
  input  logic        sd_timeout,
  output logic [16:0] tap_address,
  output logic [7:0]  tap_wdata,
  output logic        tap_we
);
  // state | meaning
  // IDLE  | CPU owns the SD controller, waiting for start
  // CSLO  | assert card chip-select
  // CMD   | send the six CMD17 bytes
  // R1    | poll for the R1 response
  // TOKEN | poll for the 0xFE start-of-data token
  // DATA  | read 512 bytes into tapdata
  // CRC   | read and drop the 2 CRC bytes
  // CSHI  | release chip-select, advance to next sector
  // FIN   | one-cycle done pulse
  // FAIL  | latch error, then release chip-select
  typedef enum logic [3:0] {
    S_IDLE, S_CSLO, S_CMD, S_R1, S_TOKEN, S_DATA, S_CRC, S_CSHI, S_FIN, S_FAIL
  } state_t;
  typedef enum logic [1:0] {PH_ISSUE, PH_WAIT, PH_POLL} phase_t;

  localparam logic [15:0] R1_LOAD    = 16'(R1_TRIES);
  localparam logic [15:0] TOKEN_LOAD = 16'(TOKEN_TRIES);
  localparam logic [15:0] CMD_LOAD   = 16'd6;
  localparam logic [15:0] DATA_LOAD  = 16'd512;
  localparam logic [15:0] CRC_LOAD   = 16'd2;

  state_t      state_q, state_d;
  phase_t      ph_q, ph_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] lba_q, lba_d;
  logic [7:0]  rem_q, rem_d;
  logic [16:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic        in_op, op_done, accept, active;
  logic [7:0]  cmd_byte;

  assign in_op   = state_q inside {S_CSLO, S_CMD, S_R1, S_TOKEN, S_DATA, S_CRC, S_CSHI};
  assign op_done = in_op && (ph_q == PH_POLL) && !sd_busy;
  assign accept  = (state_q == S_IDLE) && start && !sd_busy && !cpu_sd_signal;
  assign active  = (state_q != S_IDLE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ph_q    <= PH_ISSUE;
      cnt_q   <= '0;
      lba_q   <= '0;
      rem_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      lba_q   <= lba_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    lba_d   = lba_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    err_d   = err_q;
    if (in_op) begin
      unique case (ph_q)
        PH_ISSUE: ph_d = PH_WAIT;
        PH_WAIT:  ph_d = PH_POLL;
        PH_POLL:  if (!sd_busy) ph_d = PH_ISSUE;
        default:  ph_d = PH_ISSUE;
      endcase
    end
    unique case (state_q)
      S_IDLE: if (accept) begin
        lba_d   = lba;
        rem_d   = count;
        addr_d  = dst;
        err_d   = 1'b0;
        ph_d    = PH_ISSUE;
        state_d = (count == 8'd0) ? S_FIN : S_CSLO;
      end
      S_CSLO: if (op_done) begin
        state_d = sd_timeout ? S_FAIL : S_CMD;
        cnt_d   = CMD_LOAD;
      end
      S_CMD: if (op_done) begin
        if (sd_timeout) state_d = S_FAIL;
        else if (cnt_q == 16'd1) begin
          state_d = S_R1;
          cnt_d   = R1_LOAD;
        end else cnt_d = cnt_q - 16'd1;
      end
      S_R1: if (op_done) begin
        if (sd_timeout) state_d = S_FAIL;
        else if (sd_din == 8'h00) begin
          state_d = S_TOKEN;
          cnt_d   = TOKEN_LOAD;
        end else if (!sd_din[7] || cnt_q == 16'd1) state_d = S_FAIL;
        else cnt_d = cnt_q - 16'd1;
      end
      S_TOKEN: if (op_done) begin
        if (sd_timeout) state_d = S_FAIL;
        else if (sd_din == 8'hFE) begin
          state_d = S_DATA;
          cnt_d   = DATA_LOAD;
        end else if (cnt_q == 16'd1) state_d = S_FAIL;
        else cnt_d = cnt_q - 16'd1;
      end
      S_DATA: if (op_done) begin
        if (sd_timeout) state_d = S_FAIL;
        else begin
          addr_d = addr_q + 17'd1;
          if (cnt_q == 16'd1) begin
            state_d = S_CRC;
            cnt_d   = CRC_LOAD;
          end else cnt_d = cnt_q - 16'd1;
        end
      end
      S_CRC: if (op_done) begin
        if (sd_timeout) state_d = S_FAIL;
        else if (cnt_q == 16'd1) state_d = S_CSHI;
        else cnt_d = cnt_q - 16'd1;
      end
      // A timeout on the CS-high itself finishes with error instead of looping via FAIL.
      S_CSHI: if (op_done) begin
        if (err_q || sd_timeout) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          rem_d   = rem_q - 8'd1;
          lba_d   = lba_q + 32'd1;
          state_d = (rem_q == 8'd1) ? S_FIN : S_CSLO;
        end
      end
      S_FIN:  state_d = S_IDLE;
      S_FAIL: begin
        err_d   = 1'b1;
        ph_d    = PH_ISSUE;
        state_d = S_CSHI;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy           = active;
    done           = (state_q == S_FIN);
    error          = err_q;
    cpu_sd_din     = sd_din;
    cpu_sd_timeout = sd_timeout;
    tap_we         = (state_q == S_DATA) && op_done && !sd_timeout;
    tap_wdata      = sd_din;
    tap_address    = addr_q;
    unique case (cnt_q)
      16'd6:   cmd_byte = 8'h51;
      16'd5:   cmd_byte = lba_q[31:24];
      16'd4:   cmd_byte = lba_q[23:16];
      16'd3:   cmd_byte = lba_q[15:8];
      16'd2:   cmd_byte = lba_q[7:0];
      default: cmd_byte = 8'hFF;
    endcase
    if (active) begin
      sd_signal   = in_op && (ph_q == PH_ISSUE);
      sd_cmd      = (state_q == S_CSLO) ? 2'd1 : (state_q == S_CSHI) ? 2'd2 : 2'd0;
      sd_out      = (state_q == S_CMD) ? cmd_byte : 8'hFF;
      cpu_sd_busy = 1'b1;
    end else begin
      sd_signal   = cpu_sd_signal;
      sd_cmd      = cpu_sd_cmd;
      sd_out      = cpu_sd_out;
      cpu_sd_busy = sd_busy;
    end
  end
endmodule

// File: tb/tb_sdtap_dma.sv
// Bench for sdtap_dma: behavioural SD card model plus scoreboards for command
// bytes, tapdata writes and done/error outcomes.
module tb_sdtap_dma;
  logic        clock = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [31:0] lba = '0;
  logic [7:0]  count = '0;
  logic [16:0] dst = '0;
  logic        busy, done, error;
  logic        cpu_sd_signal = 1'b0;
  logic [1:0]  cpu_sd_cmd = '0;
  logic [7:0]  cpu_sd_out = '0;
  logic [7:0]  cpu_sd_din;
  logic        cpu_sd_busy, cpu_sd_timeout;
  logic        sd_signal;
  logic [1:0]  sd_cmd;
  logic [7:0]  sd_out;
  logic [7:0]  sd_din = '0;
  logic        sd_busy = 1'b0, sd_timeout = 1'b0;
  logic [16:0] tap_address;
  logic [7:0]  tap_wdata;
  logic        tap_we;

  sdtap_dma dut (
    .clock(clock), .reset_n(reset_n), .start(start), .lba(lba), .count(count), .dst(dst),
    .busy(busy), .done(done), .error(error),
    .cpu_sd_signal(cpu_sd_signal), .cpu_sd_cmd(cpu_sd_cmd), .cpu_sd_out(cpu_sd_out),
    .cpu_sd_din(cpu_sd_din), .cpu_sd_busy(cpu_sd_busy), .cpu_sd_timeout(cpu_sd_timeout),
    .sd_signal(sd_signal), .sd_cmd(sd_cmd), .sd_out(sd_out),
    .sd_din(sd_din), .sd_busy(sd_busy), .sd_timeout(sd_timeout),
    .tap_address(tap_address), .tap_wdata(tap_wdata), .tap_we(tap_we)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0;
  logic [24:0] exp_wr[$];
  logic [7:0]  exp_cmd[$];
  logic        exp_err[$];
  int done_cnt = 0, busy_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // SD card model, driven 1 time unit after each rising edge
  localparam int M_IDLE = 0, M_CMD = 1, M_R1 = 2, M_TOK = 3, M_DATA = 4, M_CRC = 5;
  int mp = M_IDLE, cmd_n = 0, poll_n = 0, data_n = 0, crc_n = 0, lat = 0;
  int ops = 0, r1_polls = 0, cs_lo = 0, cs_hi = 0, inits = 0, last_cmd = 0;
  int r1_at = 1, tok_at = 2, to_at = -1;
  bit r1_never = 1'b0;
  logic [7:0] resp;
  logic       to_p;

  always @(posedge clock) begin
    #1;
    if (!reset_n) begin
      sd_busy = 1'b0; sd_timeout = 1'b0; mp = M_IDLE;
    end else if (sd_busy) begin
      lat--;
      if (lat <= 0) begin
        sd_busy = 1'b0; sd_din = resp; sd_timeout = to_p;
      end
    end else if (sd_signal) begin
      ops++; last_cmd = int'(sd_cmd); to_p = 1'b0; resp = 8'h3C;
      case (sd_cmd)
        2'd1: begin cs_lo++; mp = M_CMD; cmd_n = 0; end
        2'd2: cs_hi++;
        2'd3: inits++;
        default: begin
          resp = 8'hFF;
          case (mp)
            M_CMD: begin
              if (exp_cmd.size() == 0) begin
                checks++; errors++;
                $display("FAIL cmd_unexp actual=0x%0h expected=none", sd_out);
              end else chk("cmd_byte", 32'(sd_out), 32'(exp_cmd.pop_front()));
              cmd_n++;
              if (cmd_n == 6) begin mp = M_R1; poll_n = 0; end
            end
            M_R1: begin
              r1_polls++;
              chk("r1_out", 32'(sd_out), 32'hFF);
              if (!r1_never && poll_n == r1_at) begin resp = 8'h00; mp = M_TOK; poll_n = 0; end
              else poll_n++;
            end
            M_TOK: begin
              if (poll_n == tok_at) begin resp = 8'hFE; mp = M_DATA; data_n = 0; end
              else poll_n++;
            end
            M_DATA: begin
              chk("data_out", 32'(sd_out), 32'hFF);
              resp = 8'(data_n % 256);
              to_p = (data_n == to_at);
              data_n++;
              if (data_n == 512) begin mp = M_CRC; crc_n = 0; end
            end
            M_CRC: begin
              resp = 8'hA5; crc_n++;
              if (crc_n == 2) mp = M_IDLE;
            end
            default: resp = 8'hFF;
          endcase
        end
      endcase
      sd_busy = 1'b1;
      lat = 1 + (ops % 3);
    end
  end

  // Output monitor: pops the scoreboards whenever the DUT presents a write or done
  always @(negedge clock) begin
    logic [24:0] e;
    if (busy) busy_cyc++;
    if (tap_we) begin
      if (exp_wr.size() == 0) begin
        checks++; errors++;
        $display("FAIL tap_unexp actual=0x%0h/0x%0h expected=none", tap_address, tap_wdata);
      end else begin
        e = exp_wr.pop_front();
        chk("tap_addr", 32'(tap_address), 32'(e[24:8]));
        chk("tap_data", 32'(tap_wdata), 32'(e[7:0]));
      end
    end
    if (done) begin
      done_cnt++;
      if (exp_err.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexp actual=1 expected=0");
      end else chk("done_error", 32'(error), 32'(exp_err.pop_front()));
    end
  end

  task automatic do_start(input logic [31:0] l, input logic [7:0] c, input logic [16:0] d);
    @(negedge clock);
    lba = l; count = c; dst = d; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic push_sector(input logic [31:0] l);
    exp_cmd.push_back(8'h51);
    exp_cmd.push_back(l[31:24]);
    exp_cmd.push_back(l[23:16]);
    exp_cmd.push_back(l[15:8]);
    exp_cmd.push_back(l[7:0]);
    exp_cmd.push_back(8'hFF);
  endtask

  task automatic push_writes(input logic [16:0] base, input int n);
    logic [16:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + 17'(i);
      exp_wr.push_back({a, 8'(i % 256)});
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clock); n++;
    end
    if (done_cnt == d0) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_done expected=done within %0d cycles", name, budget);
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic chk_queues(input string name);
    chk({name, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
    chk({name, "_cmd_left"}, 32'(exp_cmd.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0, h0, o0, b0, n;
    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_tap_we", 32'(tap_we), 32'd0);
    chk("rst_tap_addr", 32'(tap_address), 32'd0);
    reset_n = 1'b1;

    // idle mirror, and start refused while CPU signals / SD busy
    @(negedge clock);
    cpu_sd_cmd = 2'd2; cpu_sd_out = 8'hA5;
    #1;
    chk("mir_cmd", 32'(sd_cmd), 32'd2);
    chk("mir_out", 32'(sd_out), 32'hA5);
    chk("mir_sig0", 32'(sd_signal), 32'd0);
    @(negedge clock);
    cpu_sd_signal = 1'b1; start = 1'b1; count = 8'd1;
    #1 chk("mir_sig1", 32'(sd_signal), 32'd1);
    @(negedge clock);
    cpu_sd_signal = 1'b0;
    chk("rej_cpu_busy", 32'(busy), 32'd0);
    chk("mir_busy", 32'(cpu_sd_busy), 32'd1);
    @(negedge clock);
    start = 1'b0;
    chk("rej_sd_busy", 32'(busy), 32'd0);
    repeat (6) @(negedge clock);
    chk("mir_din", 32'(cpu_sd_din), 32'h3C);
    chk("mir_idle_busy", 32'(cpu_sd_busy), 32'd0);
    chk("mir_cs_hi", 32'(cs_hi), 32'd1);

    // single sector
    d0 = done_cnt;
    push_sector(32'h0000_1234); push_writes(17'h00100, 512); exp_err.push_back(1'b0);
    do_start(32'h0000_1234, 8'd1, 17'h00100);
    wait_done("t1", 20000);
    chk_queues("t1");
    chk("t1_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t1_busy_after", 32'(busy), 32'd0);

    // three sectors, lba and address both wrap
    d0 = done_cnt; h0 = cs_hi;
    push_sector(32'hFFFF_FFFE); push_sector(32'hFFFF_FFFF); push_sector(32'h0000_0000);
    push_writes(17'h1FF00, 1536); exp_err.push_back(1'b0);
    do_start(32'hFFFF_FFFE, 8'd3, 17'h1FF00);
    wait_done("t2", 40000);
    chk_queues("t2");
    chk("t2_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t2_cs_hi", 32'(cs_hi - h0), 32'd3);

    // R1 never answers
    r1_never = 1'b1; r0 = r1_polls; h0 = cs_hi;
    push_sector(32'h0000_0042); exp_err.push_back(1'b1);
    do_start(32'h0000_0042, 8'd2, 17'h00000);
    wait_done("t3", 2000);
    r1_never = 1'b0;
    chk_queues("t3");
    chk("t3_r1_polls", 32'(r1_polls - r0), 32'd8);
    chk("t3_cs_hi", 32'(cs_hi - h0), 32'd1);
    chk("t3_last_cmd", 32'(last_cmd), 32'd2);
    chk("t3_error", 32'(error), 32'd1);

    // timeout on data byte index 100
    to_at = 100; h0 = cs_hi;
    push_sector(32'h0000_0500); push_writes(17'h01000, 100); exp_err.push_back(1'b1);
    do_start(32'h0000_0500, 8'd1, 17'h01000);
    wait_done("t4", 5000);
    to_at = -1;
    chk_queues("t4");
    chk("t4_cs_hi", 32'(cs_hi - h0), 32'd1);
    chk("t4_error", 32'(error), 32'd1);
    push_sector(32'h0000_0007); push_writes(17'h0AAAA, 512); exp_err.push_back(1'b0);
    do_start(32'h0000_0007, 8'd1, 17'h0AAAA);
    chk("t4_err_clr", 32'(error), 32'd0);
    wait_done("t4b", 20000);
    chk_queues("t4b");

    // CPU request and new start while busy are both ignored
    d0 = done_cnt;
    push_sector(32'h0000_0055); push_writes(17'h02000, 512); exp_err.push_back(1'b0);
    do_start(32'h0000_0055, 8'd1, 17'h02000);
    repeat (20) @(negedge clock);
    cpu_sd_signal = 1'b1; cpu_sd_cmd = 2'd3; cpu_sd_out = 8'h11;
    #1;
    chk("t5_cpu_busy", 32'(cpu_sd_busy), 32'd1);
    chk("t5_no_fwd_cmd", 32'(sd_cmd), 32'd0);
    chk("t5_cpu_din", 32'(cpu_sd_din), 32'(sd_din));
    @(negedge clock);
    cpu_sd_signal = 1'b0; cpu_sd_cmd = 2'd0;
    do_start(32'h0000_DEAD, 8'd5, 17'h00000);
    wait_done("t5", 20000);
    chk_queues("t5");
    chk("t5_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t5_inits", 32'(inits), 32'd0);

    // reset in the middle of DATA, then a zero-count start
    push_sector(32'h0000_0099); push_writes(17'h00300, 512); exp_err.push_back(1'b0);
    do_start(32'h0000_0099, 8'd1, 17'h00300);
    n = 0;
    while (exp_wr.size() > 462 && n < 5000) begin @(negedge clock); n++; end
    chk("t6_reached_data", 32'(exp_wr.size() <= 462), 32'd1);
    reset_n = 1'b0;
    @(posedge clock); #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_tap_we", 32'(tap_we), 32'd0);
    chk("t6_error", 32'(error), 32'd0);
    chk("t6_tap_addr", 32'(tap_address), 32'd0);
    chk("t6_sd_signal", 32'(sd_signal), 32'd0);
    exp_wr.delete(); exp_cmd.delete(); exp_err.delete();
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    o0 = ops; b0 = busy_cyc; d0 = done_cnt;
    exp_err.push_back(1'b0);
    do_start(32'h0000_0001, 8'd0, 17'h00000);
    wait_done("t6z", 20);
    chk("t6z_busy_cycles", 32'(busy_cyc - b0), 32'd1);
    chk("t6z_sd_ops", 32'(ops - o0), 32'd0);
    chk("t6z_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t6z_error", 32'(error), 32'd0);
    chk("final_err_left", 32'(exp_err.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
